// File: rtl/in12_keypad_scanner.sv
// in12_keypad_scanner
// Scans the front-panel key matrix one column at a time, debounces whole frames and
// turns newly pressed keys into single-cycle events for the DekatronPC core.
//
// Ports:
//   Clk              in   single clock, rising edge
//   Rst              in   synchronous, active-high reset
//   Col              out  column drive, active-low, one-hot
//   Row              in   row sense, active-low, already synchronised
//   key_valid        out  one-cycle strobe for a newly pressed key
//   key_code         out  col*ROWS + row of the last reported key, held between events
//   key_any          out  high while any debounced key is down
//   key_dpc_*        out  one-cycle strobes for codes 0..4
module in12_keypad_scanner #(
  parameter int unsigned COLS     = 4,
  parameter int unsigned ROWS     = 4,
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned DEBOUNCE = 3,
  localparam int unsigned CodeW   = $clog2(ROWS * COLS)
) (
  input  logic             Clk,
  input  logic             Rst,
  output logic [COLS-1:0]  Col,
  input  logic [ROWS-1:0]  Row,
  output logic             key_valid,
  output logic [CodeW-1:0] key_code,
  output logic             key_any,
  output logic             key_dpc_hard_rst,
  output logic             key_dpc_soft_rst,
  output logic             key_dpc_halt,
  output logic             key_dpc_step,
  output logic             key_dpc_run
);

  localparam int unsigned Keys = ROWS * COLS;
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned StW  = $clog2(DEBOUNCE + 1);

  localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
  localparam logic [ColW-1:0] ColLast   = ColW'(COLS - 1);
  localparam logic [StW:0]    DebTarget = (StW + 1)'(DEBOUNCE);

  logic [DivW-1:0]  div_q, div_d;
  logic [ColW-1:0]  col_q, col_d;
  logic [Keys-1:0]  frame_q, frame_d;
  logic             frame_end_q, frame_end_d;
  logic [Keys-1:0]  prev_q, prev_d;
  logic [StW-1:0]   stable_q, stable_d;
  logic [Keys-1:0]  deb_q, deb_d;
  logic [Keys-1:0]  pending_q, pending_d;
  logic             valid_q, valid_d;
  logic [CodeW-1:0] code_q, code_d;
  logic             any_q, any_d;
  logic [4:0]       dpc_q, dpc_d;

  logic [StW:0]        stable_inc;
  logic                accept;
  logic [Keys-1:0]     new_bits;
  logic [Keys-1:0]     src;
  logic [Keys-1:0]     low_hot;
  logic [CodeW-1:0]    low_code;
  int unsigned         low_int;

  always_comb begin
    Col        = '1;
    Col[col_q] = 1'b0;
  end

  always_comb begin
    div_d       = div_q;
    col_d       = col_q;
    frame_d     = frame_q;
    frame_end_d = 1'b0;
    prev_d      = prev_q;
    stable_d    = stable_q;
    deb_d       = deb_q;

    // Scan: sample the rows on the last clock of each column dwell.
    if (div_q == DivLast) begin
      div_d                        = '0;
      frame_d[col_q*ROWS +: ROWS]  = ~Row;
      frame_end_d                  = (col_q == ColLast);
      col_d                        = (col_q == ColLast) ? '0 : col_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end

    // Update cycle: compare the complete frame against the previous one.
    stable_inc = {1'b0, stable_q} + 1'b1;
    accept     = frame_end_q && (frame_q == prev_q) && (stable_inc >= DebTarget) &&
                 (frame_q != deb_q);
    new_bits   = accept ? (frame_q & ~deb_q) : '0;

    if (frame_end_q) begin
      prev_d = frame_q;
      if (frame_q == prev_q) begin
        stable_d = (stable_inc >= DebTarget) ? StW'(DEBOUNCE) : stable_inc[StW-1:0];
      end else begin
        stable_d = '0;
      end
      if (accept) begin
        deb_d = frame_q;
      end
    end

    // Drain: old pending bits go first; an empty queue lets fresh presses out at once.
    src      = (pending_q != '0) ? pending_q : new_bits;
    low_int  = 0;
    low_code = '0;
    for (int i = Keys - 1; i >= 0; i--) begin
      if (src[i]) begin
        low_int  = i;
        low_code = CodeW'(i);
      end
    end
    low_hot = '0;
    if (src != '0) begin
      low_hot[low_code] = 1'b1;
    end
    pending_d = (pending_q | new_bits) & ~low_hot;

    valid_d  = (src != '0);
    code_d   = valid_d ? low_code : code_q;
    dpc_d    = '0;
    dpc_d[0] = valid_d && (low_int == 0);
    dpc_d[1] = valid_d && (low_int == 1);
    dpc_d[2] = valid_d && (low_int == 2);
    dpc_d[3] = valid_d && (low_int == 3);
    dpc_d[4] = valid_d && (low_int == 4);
    any_d    = |deb_d;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_q       <= '0;
      col_q       <= '0;
      frame_q     <= '0;
      frame_end_q <= 1'b0;
      prev_q      <= '0;
      stable_q    <= '0;
      deb_q       <= '0;
      pending_q   <= '0;
      valid_q     <= 1'b0;
      code_q      <= '0;
      any_q       <= 1'b0;
      dpc_q       <= '0;
    end else begin
      div_q       <= div_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      frame_end_q <= frame_end_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      deb_q       <= deb_d;
      pending_q   <= pending_d;
      valid_q     <= valid_d;
      code_q      <= code_d;
      any_q       <= any_d;
      dpc_q       <= dpc_d;
    end
  end

  assign key_valid        = valid_q;
  assign key_code         = code_q;
  assign key_any          = any_q;
  assign key_dpc_hard_rst = dpc_q[0];
  assign key_dpc_soft_rst = dpc_q[1];
  assign key_dpc_halt     = dpc_q[2];
  assign key_dpc_step     = dpc_q[3];
  assign key_dpc_run      = dpc_q[4];

endmodule

// File: tb/tb_in12_keypad_scanner.sv
// Directed bench for in12_keypad_scanner with a 4x4 switch-matrix model.
// Cycle 0 is the first clock after Rst is released; frame f spans cycles 16f..16f+15
// and its update cycle is 16f+16.
module tb_in12_keypad_scanner;

  logic       Clk;
  logic       Rst;
  logic [3:0] Col;
  logic [3:0] Row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_any;
  logic       key_dpc_hard_rst;
  logic       key_dpc_soft_rst;
  logic       key_dpc_halt;
  logic       key_dpc_step;
  logic       key_dpc_run;

  logic [15:0] pressed;
  logic [4:0]  dpc;
  int          checks;
  int          errors;
  int          cyc;

  in12_keypad_scanner dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .Col              (Col),
    .Row              (Row),
    .key_valid        (key_valid),
    .key_code         (key_code),
    .key_any          (key_any),
    .key_dpc_hard_rst (key_dpc_hard_rst),
    .key_dpc_soft_rst (key_dpc_soft_rst),
    .key_dpc_halt     (key_dpc_halt),
    .key_dpc_step     (key_dpc_step),
    .key_dpc_run      (key_dpc_run)
  );

  assign dpc = {key_dpc_run, key_dpc_step, key_dpc_halt, key_dpc_soft_rst, key_dpc_hard_rst};

  // Pressed switches pull their row low while their column is driven low.
  always_comb begin
    Row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (!Col[c]) Row = Row & ~pressed[c*4 +: 4];
    end
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    cyc = 0;
  endtask

  // Checks that no strobe fires on cycles cyc..t-1; returns at cycle t.
  task automatic quiet_to(input int t, input string tag);
    while (cyc < t) begin
      chk(tag, 32'({key_valid, dpc}), 32'd0);
      step();
    end
  endtask

  task automatic expect_event(input int code, input string tag);
    logic [4:0] exp_dpc;
    exp_dpc = (code < 5) ? 5'(1 << code) : 5'd0;
    chk({tag, "_valid"}, 32'(key_valid), 32'd1);
    chk({tag, "_code"}, 32'(key_code), 32'(code));
    chk({tag, "_dpc"}, 32'(dpc), 32'(exp_dpc));
    step();
  endtask

  initial begin
    logic [3:0] ec;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    Rst     = 1'b1;
    pressed = '0;

    // Reset values and idle scan pattern.
    do_reset();
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_any", 32'(key_any), 32'd0);
    for (int k = 0; k < 32; k++) begin
      ec = ~(4'b0001 << ((k / 4) % 4));
      chk("scan_col", 32'(Col), 32'(ec));
      chk("scan_quiet", 32'({key_any, key_valid, dpc}), 32'd0);
      step();
    end

    // Single press of code 6, held, then released.
    pressed = 16'h0040;
    do_reset();
    quiet_to(65, "single_pre");
    expect_event(6, "single");
    chk("single_any", 32'(key_any), 32'd1);
    quiet_to(130, "single_held");
    pressed = '0;
    quiet_to(192, "single_rel");
    chk("rel_any_hold", 32'(key_any), 32'd1);
    quiet_to(193, "single_rel2");
    chk("rel_any_drop", 32'(key_any), 32'd0);

    // DPC step key, code 3.
    pressed = 16'h0008;
    do_reset();
    quiet_to(65, "step_pre");
    expect_event(3, "step");
    quiet_to(80, "step_post");

    // Simultaneous codes 0, 4 and 9.
    pressed = 16'h0211;
    do_reset();
    quiet_to(65, "multi_pre");
    expect_event(0, "multi0");
    expect_event(4, "multi4");
    expect_event(9, "multi9");
    quiet_to(130, "multi_held");

    // Code 5 bouncing on alternate frames, then held.
    pressed = 16'h0020;
    do_reset();
    quiet_to(16, "bounce");
    pressed = '0;
    quiet_to(32, "bounce");
    pressed = 16'h0020;
    quiet_to(48, "bounce");
    pressed = '0;
    quiet_to(64, "bounce");
    pressed = 16'h0020;
    quiet_to(80, "bounce");
    pressed = '0;
    quiet_to(96, "bounce");
    pressed = 16'h0020;
    quiet_to(161, "bounce_hold");
    expect_event(5, "bounce1");
    quiet_to(176, "bounce_held");
    pressed = '0;
    quiet_to(256, "bounce_rel");
    pressed = 16'h0020;
    quiet_to(321, "bounce_repress");
    expect_event(5, "bounce2");
    quiet_to(340, "bounce_end");

    // Reset during the second of three events.
    pressed = 16'h0211;
    do_reset();
    quiet_to(65, "mid_pre");
    expect_event(0, "mid0");
    chk("mid4_valid", 32'(key_valid), 32'd1);
    chk("mid4_code", 32'(key_code), 32'd4);
    chk("mid4_dpc", 32'(dpc), 32'h10);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("mid_rst_strobes", 32'({key_valid, dpc}), 32'd0);
    chk("mid_rst_col", 32'(Col), 32'he);
    Rst = 1'b0;
    cyc = 0;
    chk("mid_rst_any", 32'(key_any), 32'd0);
    quiet_to(65, "mid_after");
    expect_event(0, "mid_rereport");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
